// File: rtl/pll_rst_ctrl_pkg.sv
// Shared constants for the PLL reset controller: state encoding, counter
// width and the saturating retry increment.
package pll_rst_ctrl_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned RETRY_W = 8;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [RETRY_W-1:0] retry_t;

  typedef enum logic [1:0] {
    PLL_RST     = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } state_t;

  function automatic retry_t sat_inc(input retry_t v);
    return (v == '1) ? v : v + retry_t'(1);
  endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync_bit.sv
// Single-bit synchronizer with parameterized depth and asynchronous clear.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and
// releases the system reset, retrying on timeout or lock loss.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  output logic       o_pll_rst,
  output logic       o_rst,
  output logic       o_ready,
  output logic [7:0] o_retries
);

  localparam cnt_t PLL_RST_LAST = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);

  logic   rst_sync_n;
  logic   lock_s;
  state_t state, state_n;
  cnt_t   cnt, cnt_n;
  retry_t retries_n;

  sync_bit #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  // Lock synchronizer is held clear for as long as the internal reset is.
  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (i_clk),
    .clr_n (rst_sync_n),
    .d     (i_pll_locked),
    .q     (lock_s)
  );

  // Lock checks come first in each branch so lock loss beats terminal count.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + cnt_t'(1);
    retries_n = o_retries;
    unique case (state)
      PLL_RST: begin
        if (cnt == PLL_RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE_WAIT;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n   = PLL_RST;
          cnt_n     = '0;
          retries_n = sat_inc(o_retries);
        end
      end
      STABLE_WAIT: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          state_n   = PLL_RST;
          retries_n = sat_inc(o_retries);
        end
      end
      default: begin
        state_n = PLL_RST;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      o_retries <= '0;
      o_pll_rst <= 1'b1;
      o_rst     <= 1'b1;
      o_ready   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_retries <= retries_n;
      o_pll_rst <= (state_n == PLL_RST);
      o_rst     <= (state_n != RUN);
      o_ready   <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with short counter parameters.
module tb_pll_rst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retries;

  int unsigned n_tests;
  int unsigned n_fail;

  pll_rst_ctrl #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (100),
    .SYNC_STAGES         (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pll_locked (locked),
    .o_pll_rst    (pll_rst),
    .o_rst        (sys_rst),
    .o_ready      (ready),
    .o_retries    (retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    locked  = 1'b0;

    // Reset state
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst", 32'(sys_rst), 1);
    chk("rst_ready",   32'(ready),   0);
    chk("rst_retries", 32'(retries), 0);

    // Release with lock arriving at edge 20 after release
    rst_n = 1'b1;
    tick(2);
    chk("rel_pll_rst_e2", 32'(pll_rst), 1);
    tick(3);
    chk("rel_pll_rst_e5", 32'(pll_rst), 1);
    tick(1);
    chk("rel_pll_rst_e6", 32'(pll_rst), 0);
    chk("rel_sys_rst_e6", 32'(sys_rst), 1);
    tick(13);
    locked = 1'b1;
    tick(10);
    chk("rel_sys_rst_e29", 32'(sys_rst), 1);
    chk("rel_ready_e29",   32'(ready),   0);
    tick(1);
    chk("rel_sys_rst_e30", 32'(sys_rst), 0);
    chk("rel_ready_e30",   32'(ready),   1);
    chk("rel_pll_rst_e30", 32'(pll_rst), 0);
    chk("rel_retries_e30", 32'(retries), 0);

    // One-cycle lock drop while running
    tick(2);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    chk("drop_sys_rst_k2", 32'(sys_rst), 0);
    chk("drop_pll_rst_k2", 32'(pll_rst), 0);
    tick(1);
    chk("drop_sys_rst_k3", 32'(sys_rst), 1);
    chk("drop_pll_rst_k3", 32'(pll_rst), 1);
    chk("drop_ready_k3",   32'(ready),   0);
    chk("drop_retries_k3", 32'(retries), 1);
    tick(3);
    chk("drop_pll_rst_k6", 32'(pll_rst), 1);
    tick(1);
    chk("drop_pll_rst_k7", 32'(pll_rst), 0);
    tick(8);
    chk("drop_sys_rst_k15", 32'(sys_rst), 1);
    tick(1);
    chk("drop_sys_rst_k16", 32'(sys_rst), 0);
    chk("drop_ready_k16",   32'(ready),   1);
    chk("drop_retries_k16", 32'(retries), 1);

    // Lose lock for good, then a 5-cycle lock pulse in WAIT_LOCK
    locked = 1'b0;
    tick(3);
    chk("loss_retries", 32'(retries), 2);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    tick(4);
    chk("loss_pll_rst_end", 32'(pll_rst), 0);
    tick(3);
    locked = 1'b1;
    for (int unsigned i = 1; i <= 107; i++) begin
      tick(1);
      if (i == 5) locked = 1'b0;
      chk("pulse_sys_rst", 32'(sys_rst), 1);
    end
    chk("pulse_pll_rst_pre", 32'(pll_rst), 0);
    chk("pulse_retries_pre", 32'(retries), 2);
    // Timeout lands 100 edges after the pulse's return to WAIT_LOCK
    tick(1);
    chk("pulse_pll_rst_to", 32'(pll_rst), 1);
    chk("pulse_retries_to", 32'(retries), 3);

    // Lock held low: PLL reset re-pulses every 104 cycles
    for (int unsigned t = 1; t <= 208; t++) begin
      tick(1);
      chk("period_pll_rst", 32'(pll_rst), ((t % 104) < 4) ? 1 : 0);
      chk("period_retries", 32'(retries), 3 + ((t >= 104) ? 1 : 0) + ((t >= 208) ? 1 : 0));
    end

    // Asynchronous reset in STABLE_WAIT
    locked = 1'b1;
    tick(7);
    chk("async_pre_pll_rst", 32'(pll_rst), 0);
    chk("async_pre_sys_rst", 32'(sys_rst), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst", 32'(pll_rst), 1);
    chk("async_sys_rst", 32'(sys_rst), 1);
    chk("async_ready",   32'(ready),   0);
    chk("async_retries", 32'(retries), 0);

    // 300 timeouts: retry count saturates
    locked = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int unsigned n = 1; n <= 31210; n++) begin
      tick(1);
      if (n == 105)   chk("sat_r105",   32'(retries), 0);
      if (n == 106)   chk("sat_r106",   32'(retries), 1);
      if (n == 26521) chk("sat_r26521", 32'(retries), 254);
      if (n == 26522) chk("sat_r26522", 32'(retries), 255);
      if (n == 26626) chk("sat_r26626", 32'(retries), 255);
      if (n == 31202) begin
        chk("sat_r31202",     32'(retries), 255);
        chk("sat_pll_rst",    32'(pll_rst), 1);
      end
      if (n == 31210) chk("sat_sys_rst", 32'(sys_rst), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
